// File: rtl/fc_argmax_unit.sv
// ============================================================================
// Module   : fc_argmax_unit
// Purpose  : Classifier output stage; captures the FC results and scans them
//            serially for the index and value of the signed maximum.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fc_argmax_unit #(
    parameter int SIG_DATA_WIDTH = 32,
    parameter int NUM_OUT        = 10,
    parameter int INDEX_WIDTH    = $clog2(NUM_OUT)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start_from_previous,
    input  logic [NUM_OUT*SIG_DATA_WIDTH-1:0] data_in,
    output logic                              end_to_previous,
    output logic                              busy,
    output logic [INDEX_WIDTH-1:0]            class_index,
    output logic [SIG_DATA_WIDTH-1:0]         max_value,
    output logic                              result_valid
);

    localparam logic [INDEX_WIDTH-1:0] c_LAST_IDX = INDEX_WIDTH'(NUM_OUT - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SCAN = 1'b1
    } state_t;

    state_t                            r_state;
    state_t                            w_state_next;
    logic                              w_capture;
    logic                              w_last;
    logic                              w_greater;
    logic        [INDEX_WIDTH-1:0]     r_cnt;
    logic signed [SIG_DATA_WIDTH-1:0]  r_buf [NUM_OUT];
    logic signed [SIG_DATA_WIDTH-1:0]  w_neuron [NUM_OUT];
    logic signed [SIG_DATA_WIDTH-1:0]  r_best_val;
    logic        [INDEX_WIDTH-1:0]     r_best_idx;
    logic signed [SIG_DATA_WIDTH-1:0]  w_best_val_nx;
    logic        [INDEX_WIDTH-1:0]     w_best_idx_nx;

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_unpack
        assign w_neuron[k] = data_in[k*SIG_DATA_WIDTH +: SIG_DATA_WIDTH];
    end

    // Strict compare: on ties the earlier (lower) index is kept.
    assign w_greater     = r_buf[r_cnt] > r_best_val;
    assign w_best_val_nx = w_greater ? r_buf[r_cnt] : r_best_val;
    assign w_best_idx_nx = w_greater ? r_cnt : r_best_idx;
    assign w_last        = (r_cnt == c_LAST_IDX);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        end_to_previous = 1'b0;
        busy            = 1'b0;
        w_capture       = 1'b0;
        case (r_state)
            S_IDLE: begin
                end_to_previous = 1'b1;
                if (start_from_previous) begin
                    w_capture    = 1'b1;
                    w_state_next = S_SCAN;
                end
            end
            S_SCAN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt        <= '0;
            r_best_val   <= '0;
            r_best_idx   <= '0;
            class_index  <= '0;
            max_value    <= '0;
            result_valid <= 1'b0;
            for (int k = 0; k < NUM_OUT; k++) begin
                r_buf[k] <= '0;
            end
        end else begin
            result_valid <= 1'b0;
            if (w_capture) begin
                for (int k = 0; k < NUM_OUT; k++) begin
                    r_buf[k] <= w_neuron[k];
                end
                // Neuron 0 seeds the running best, so the scan starts at 1.
                r_best_val <= w_neuron[0];
                r_best_idx <= '0;
                r_cnt      <= INDEX_WIDTH'(1);
            end else if (r_state == S_SCAN) begin
                r_best_val <= w_best_val_nx;
                r_best_idx <= w_best_idx_nx;
                if (w_last) begin
                    class_index  <= w_best_idx_nx;
                    max_value    <= w_best_val_nx;
                    result_valid <= 1'b1;
                    r_cnt        <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fc_argmax_unit.sv
// ============================================================================
// Module   : tb_fc_argmax_unit
// Purpose  : Directed self-checking bench for fc_argmax_unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fc_argmax_unit;

    localparam int W  = 32;
    localparam int N  = 10;
    localparam int IW = 4;

    logic              clk;
    logic              reset;
    logic              start_from_previous;
    logic [N*W-1:0]    data_in;
    logic              end_to_previous;
    logic              busy;
    logic [IW-1:0]     class_index;
    logic [W-1:0]      max_value;
    logic              result_valid;

    int n_assert;
    int n_fail;
    logic [31:0] held_idx;
    logic [31:0] held_val;

    fc_argmax_unit #(
        .SIG_DATA_WIDTH (W),
        .NUM_OUT        (N),
        .INDEX_WIDTH    (IW)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .start_from_previous (start_from_previous),
        .data_in             (data_in),
        .end_to_previous     (end_to_previous),
        .busy                (busy),
        .class_index         (class_index),
        .max_value           (max_value),
        .result_valid        (result_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [N*W-1:0] pack(input int v [N]);
        logic [N*W-1:0] d;
        for (int k = 0; k < N; k++) d[k*W +: W] = v[k];
        return d;
    endfunction

    // Start in cycle 0, expect busy in 1..9 and a one-cycle result in cycle 10.
    task automatic run(input logic [N*W-1:0] d, input logic [31:0] exp_i,
                       input logic [31:0] exp_v, input string tag);
        start_from_previous = 1'b1;
        data_in             = d;
        tick();
        start_from_previous = 1'b0;
        data_in             = ~d;
        for (int c = 1; c < N; c++) begin
            chk({tag, "_etp_low"}, {31'b0, end_to_previous}, 32'd0);
            chk({tag, "_busy"},    {31'b0, busy},            32'd1);
            chk({tag, "_rv_low"},  {31'b0, result_valid},    32'd0);
            chk({tag, "_idx_hold"}, {28'b0, class_index},    held_idx);
            chk({tag, "_val_hold"}, max_value,                held_val);
            tick();
        end
        chk({tag, "_rv"},  {31'b0, result_valid},    32'd1);
        chk({tag, "_idx"}, {28'b0, class_index},     exp_i);
        chk({tag, "_val"}, max_value,                exp_v);
        chk({tag, "_etp"}, {31'b0, end_to_previous}, 32'd1);
        held_idx = exp_i;
        held_val = exp_v;
        tick();
        chk({tag, "_rv_pulse"}, {31'b0, result_valid}, 32'd0);
        chk({tag, "_idx_after"}, {28'b0, class_index}, held_idx);
    endtask

    initial begin
        int a [N];
        logic [N*W-1:0] da, db, dc;
        n_assert            = 0;
        n_fail              = 0;
        held_idx            = 0;
        held_val            = 0;
        reset               = 1'b1;
        start_from_previous = 1'b0;
        data_in             = '0;

        // Reset
        tick();
        tick();
        chk("rst_rv_in_reset", {31'b0, result_valid}, 32'd0);
        reset = 1'b0;
        tick();
        chk("rst_idx",  {28'b0, class_index},     32'd0);
        chk("rst_val",  max_value,                32'd0);
        chk("rst_rv",   {31'b0, result_valid},    32'd0);
        chk("rst_etp",  {31'b0, end_to_previous}, 32'd1);
        chk("rst_busy", {31'b0, busy},            32'd0);

        // Basic argmax
        a = '{0, 5, 3, 9, 2, 1, 0, 7, 4, 8};
        run(pack(a), 32'd3, 32'd9, "basic");

        // Idle hold
        tick(); tick(); tick();
        chk("idle_idx_hold", {28'b0, class_index}, 32'd3);
        chk("idle_val_hold", max_value,            32'd9);

        // Signed values, tie -> lowest index
        a = '{-5, -5, -1, -5, -5, -5, -1, -5, -5, -5};
        run(pack(a), 32'd2, 32'hFFFF_FFFF, "signed_tie");

        // All equal at the positive limit
        for (int k = 0; k < N; k++) a[k] = 32'h7FFF_FFFF;
        run(pack(a), 32'd0, 32'h7FFF_FFFF, "all_equal");

        // Maximum at the last index
        a = '{99, 99, 99, 99, 99, 99, 99, 99, 99, 100};
        run(pack(a), 32'd9, 32'd100, "last_idx");

        // Mixed sign: -1 must lose to +1
        a = '{-1, -1, 1, -1, -1, -1, -1, -1, -1, -1};
        run(pack(a), 32'd2, 32'd1, "neg_vs_pos");

        // Start while busy is ignored; start in the result cycle is accepted
        a  = '{1, 50, 3, 4, 5, 6, 7, 8, 9, 10};
        da = pack(a);
        a  = '{0, 0, 0, 0, 0, 0, 0, 1000, 0, 0};
        db = pack(a);
        a  = '{-3, -3, -3, -3, -2, -3, -3, -3, -3, -3};
        dc = pack(a);
        start_from_previous = 1'b1;
        data_in             = da;
        tick();
        for (int c = 1; c < N; c++) begin
            start_from_previous = (c == 4);
            data_in             = (c == 4) ? db : '0;
            chk("ign_rv_low", {31'b0, result_valid}, 32'd0);
            chk("ign_busy",   {31'b0, busy},         32'd1);
            tick();
        end
        chk("ign_rv",  {31'b0, result_valid}, 32'd1);
        chk("ign_idx", {28'b0, class_index},  32'd1);
        chk("ign_val", max_value,             32'd50);
        chk("b2b_etp", {31'b0, end_to_previous}, 32'd1);
        start_from_previous = 1'b1;
        data_in             = dc;
        tick();
        start_from_previous = 1'b0;
        data_in             = '0;
        for (int c = 11; c < 2*N; c++) begin
            chk("b2b_rv_low",   {31'b0, result_valid}, 32'd0);
            chk("b2b_idx_hold", {28'b0, class_index},  32'd1);
            tick();
        end
        chk("b2b_rv",  {31'b0, result_valid}, 32'd1);
        chk("b2b_idx", {28'b0, class_index},  32'd4);
        chk("b2b_val", max_value,             32'hFFFF_FFFE);
        tick();
        chk("b2b_rv_pulse", {31'b0, result_valid}, 32'd0);

        // Reset mid-scan
        start_from_previous = 1'b1;
        data_in             = da;
        tick();
        start_from_previous = 1'b0;
        for (int c = 1; c < 5; c++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_etp",  {31'b0, end_to_previous}, 32'd1);
        chk("mid_busy", {31'b0, busy},            32'd0);
        chk("mid_idx",  {28'b0, class_index},     32'd0);
        chk("mid_val",  max_value,                32'd0);
        for (int c = 6; c <= N; c++) begin
            chk("mid_no_rv", {31'b0, result_valid}, 32'd0);
            tick();
        end
        held_idx = 0;
        held_val = 0;
        a = '{0, 5, 3, 9, 2, 1, 0, 7, 4, 8};
        run(pack(a), 32'd3, 32'd9, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
